// File: rtl/voice_mixer_if.sv
// -----------------------------------------------------------------------------
// voice_mixer_if
//
// Bundles the voice-scan inputs and the mixed-sample output handshake of
// voice_mixer.
//
//   i_voice_index     8   voice being scanned (sampled in scan phase 0)
//   i_pipeline_state  2   shared scan phase: 0 read, 1 compute, 2 update, 3 unused
//   i_sample          16  signed enveloped sample (valid in scan phase 2)
//   i_ready           1   downstream accepts o_sample
//   i_clear_flags     1   clears o_overrun and o_clip
//   o_sample          16  signed mixed frame sample
//   o_valid           1   o_sample holds an unconsumed frame
//   o_overrun         1   sticky: a frame was overwritten before being consumed
//   o_clip            1   sticky: saturation occurred
//
// Modports: master = scan pipeline / DAC side, slave = the mixer.
// -----------------------------------------------------------------------------
interface voice_mixer_if;
   logic        [7:0]  i_voice_index;
   logic        [1:0]  i_pipeline_state;
   logic signed [15:0] i_sample;
   logic               i_ready;
   logic               i_clear_flags;
   logic signed [15:0] o_sample;
   logic               o_valid;
   logic               o_overrun;
   logic               o_clip;

   modport master (
      output i_voice_index,
      output i_pipeline_state,
      output i_sample,
      output i_ready,
      output i_clear_flags,
      input  o_sample,
      input  o_valid,
      input  o_overrun,
      input  o_clip
   );

   modport slave (
      input  i_voice_index,
      input  i_pipeline_state,
      input  i_sample,
      input  i_ready,
      input  i_clear_flags,
      output o_sample,
      output o_valid,
      output o_overrun,
      output o_clip
   );
endinterface

// File: rtl/voice_mixer.sv
// -----------------------------------------------------------------------------
// voice_mixer
//
// Sums the enveloped sample of every voice in one scan (frame), scales the
// frame sum by an arithmetic right shift, saturates it to 16 bits and presents
// one mixed sample per frame over a valid/ready handshake.
//
// Ports:
//   i_clk    clock
//   i_reset  synchronous, active-high reset
//   bus      voice_mixer_if.slave (scan inputs, output handshake, sticky flags)
//
// Parameters:
//   NUM_VOICES  voices per frame (indices 0..NUM_VOICES-1, max 256)
//   ACC_W       accumulator width, >= 16 + clog2(NUM_VOICES)
//   MIX_SHIFT   arithmetic right shift of the frame sum
//   DC_SHIFT    DC-blocker pole coefficient
//
// Optional feature: define MIXER_DC_BLOCK_EN to insert a one-pole DC-blocking
// high-pass after saturation (one extra pipeline cycle). Without it the
// saturated value goes straight to the output register.
//
// Timing: the frame register loads at edge T (last voice, phase 2); the
// output register loads at T+1 (T+2 with the DC blocker).
// -----------------------------------------------------------------------------
module voice_mixer #(
   parameter int unsigned NUM_VOICES = 32,
   parameter int unsigned ACC_W      = 24,
   parameter int unsigned MIX_SHIFT  = 5,
   parameter int unsigned DC_SHIFT   = 8
) (
   input logic          i_clk,
   input logic          i_reset,
   voice_mixer_if.slave bus
);

   localparam logic [8:0] NUM_VOICES_W = 9'(NUM_VOICES);
   localparam logic [7:0] LAST_VOICE   = 8'(NUM_VOICES - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   // Bitwise complement of 0x7fff sign-extended gives -32768.
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   localparam logic [1:0] PH_READ   = 2'd0;
   localparam logic [1:0] PH_UPDATE = 2'd2;

   // Returns {clamped, value[15:0]}.
   function automatic logic [16:0] saturate(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         return {1'b1, 16'h7fff};
      end else if (v < SAT_MIN) begin
         return {1'b1, 16'h8000};
      end else begin
         return {1'b0, v[15:0]};
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Accumulation
   // ---------------------------------------------------------------------------
   logic        [7:0]       tag_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] frame_q;
   logic                    frame_load_q;

   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    accumulate;
   logic                    frame_end;

   assign sample_ext = {{(ACC_W-16){bus.i_sample[15]}}, bus.i_sample};
   assign acc_sum    = acc_q + sample_ext;

   // Tags outside the voice range are ignored entirely.
   assign accumulate = (bus.i_pipeline_state == PH_UPDATE) && ({1'b0, tag_q} < NUM_VOICES_W);
   assign frame_end  = accumulate && (tag_q == LAST_VOICE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tag_q        <= '0;
         acc_q        <= '0;
         frame_q      <= '0;
         frame_load_q <= 1'b0;
      end else begin
         if (bus.i_pipeline_state == PH_READ) begin
            tag_q <= bus.i_voice_index;
         end
         if (accumulate) begin
            // Last voice closes the frame and restarts the sum from zero, so
            // no sample falls between frames.
            acc_q <= frame_end ? '0 : acc_sum;
         end
         if (frame_end) begin
            frame_q <= acc_sum;
         end
         frame_load_q <= frame_end;
      end
   end

   // ---------------------------------------------------------------------------
   // Scale and saturate
   // ---------------------------------------------------------------------------
   logic signed [ACC_W-1:0] scaled;
   logic        [16:0]      scaled_sat;

   assign scaled     = frame_q >>> MIX_SHIFT;
   assign scaled_sat = saturate(scaled);

   logic        result_load;
   logic [15:0] result_val;
   logic        result_clip;

`ifdef MIXER_DC_BLOCK_EN
   // ---------------------------------------------------------------------------
   // DC blocker: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
   // y_prev_q doubles as the pipeline register feeding the output stage.
   // ---------------------------------------------------------------------------
   logic signed [ACC_W-1:0] x_prev_q;
   logic signed [ACC_W-1:0] y_prev_q;
   logic                    dc_load_q;
   logic                    dc_clip_q;

   logic signed [ACC_W-1:0] x_cur;
   logic signed [ACC_W-1:0] y_next;
   logic        [16:0]      y_sat;

   assign x_cur  = {{(ACC_W-16){scaled_sat[15]}}, scaled_sat[15:0]};
   assign y_next = x_cur - x_prev_q + y_prev_q - (y_prev_q >>> DC_SHIFT);
   assign y_sat  = saturate(y_prev_q);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         x_prev_q  <= '0;
         y_prev_q  <= '0;
         dc_load_q <= 1'b0;
         dc_clip_q <= 1'b0;
      end else begin
         if (frame_load_q) begin
            x_prev_q  <= x_cur;
            y_prev_q  <= y_next;
            dc_clip_q <= scaled_sat[16];
         end
         dc_load_q <= frame_load_q;
      end
   end

   always_comb begin
      result_load = dc_load_q;
      result_val  = y_sat[15:0];
      result_clip = y_sat[16] | dc_clip_q;
   end
`else
   always_comb begin
      result_load = frame_load_q;
      result_val  = scaled_sat[15:0];
      result_clip = scaled_sat[16];
   end
`endif

   // ---------------------------------------------------------------------------
   // Output register and sticky flags
   // ---------------------------------------------------------------------------
   logic [15:0] sample_q;
   logic        valid_q;
   logic        overrun_q;
   logic        clip_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         clip_q    <= 1'b0;
      end else begin
         // A new result wins over a same-cycle handshake: valid stays high.
         if (result_load) begin
            sample_q <= result_val;
            valid_q  <= 1'b1;
         end else if (valid_q && bus.i_ready) begin
            valid_q <= 1'b0;
         end

         // Setting a flag has priority over clearing it.
         if (result_load && valid_q && !bus.i_ready) begin
            overrun_q <= 1'b1;
         end else if (bus.i_clear_flags) begin
            overrun_q <= 1'b0;
         end

         if (result_load && result_clip) begin
            clip_q <= 1'b1;
         end else if (bus.i_clear_flags) begin
            clip_q <= 1'b0;
         end
      end
   end

   assign bus.o_sample  = sample_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_overrun = overrun_q;
   assign bus.o_clip    = clip_q;

endmodule
